// File: rtl/press_pkg.sv
// Shared types and the round-robin pick helper for the press arbiter.
package press_pkg;

  typedef enum logic {IDLE = 1'b0, COOL = 1'b1} arb_state_t;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr+1, ptr+2, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        c = (int'(ptr) + k) % n;
        if (!r.valid && req[c[2:0]]) begin
          r.valid = 1'b1;
          r.idx   = c[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/press_edge.sv
// Per-button rising-edge detector; prev resets high so a button held through
// reset must be released before it can fire.
module press_edge (
  input  logic clk,
  input  logic Reset,
  input  logic press,
  output logic rise
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    prev_d = press;
    rise_d = press & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/press_arbiter.sv
// Round-robin arbiter for push-button presses with a post-grant cooldown.
// Define PRESS_QUEUE_EN to hold non-granted presses pending instead of dropping them.
module press_arbiter
  import press_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int COOLDOWN = 4,
  parameter int DROP_W   = 8
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         press,
  input  logic                     enable,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = $clog2(COOLDOWN + 1);

  logic [N_REQ-1:0]   rise;
  logic [N_REQ-1:0]   pend;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   win_mask;
  logic [IDW-1:0]     win_id;
  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  rr_pick_t           pick;

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_edge
    press_edge u_edge (
      .clk   (clk),
      .Reset (Reset),
      .press (press[g]),
      .rise  (rise[g])
    );
  end

`ifdef PRESS_QUEUE_EN
  logic [N_REQ-1:0] pend_q, pend_d;

  always_comb pend_d = (pend_q | rise) & ~win_mask;

  always_ff @(posedge clk) begin
    if (Reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pend = pend_q;
`else
  assign pend = '0;
`endif

  // Winner selection
  always_comb begin
    req        = rise | pend;
    req_ext    = '0;
    req_ext[N_REQ-1:0] = req;
    ptr_ext    = 3'(ptr_q);
    pick       = rr_pick(req_ext, ptr_ext, N_REQ);
    win_mask   = '0;
    win_id     = '0;
    if (state_q == IDLE && enable && pick.valid) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (int'(pick.idx) == i) begin
          win_mask[i] = 1'b1;
          win_id      = IDW'(i);
        end
      end
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_d    = '0;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (|win_mask) begin
          grant_d    = win_mask;
          grant_id_d = win_id;
          ptr_d      = win_id;
          cnt_d      = CNT_W'(COOLDOWN - 1);
          state_d    = COOL;
        end
      end
      COOL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PRESS_QUEUE_EN
  always_comb drop_d = '0;
`else
  logic [N_REQ-1:0]  dropped;
  logic [3:0]        n_drop;
  logic [DROP_W+4:0] drop_sum;

  // Every rise that did not win this cycle is lost; count saturates.
  always_comb begin
    dropped = rise & ~win_mask;
    n_drop  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (dropped[i]) n_drop = n_drop + 4'd1;
    end
    drop_sum = {5'b0, drop_q} + (DROP_W + 5)'(n_drop);
    if (drop_sum > {5'b0, {DROP_W{1'b1}}}) drop_d = '1;
    else                                   drop_d = drop_sum[DROP_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= IDW'(N_REQ - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      drop_q     <= drop_d;
    end
  end

  // Outputs
  always_comb begin
    grant    = grant_q;
    grant_id = grant_id_q;
    busy     = (state_q == COOL);
    drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_press_arbiter.sv
// Bench for press_arbiter: directed scenarios plus randomized presses against a
// cycle-level behavioural model. Honours PRESS_QUEUE_EN like the design.
module tb_press_arbiter;

  localparam int N   = 2;
  localparam int CD  = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          Reset;
  logic [N-1:0]  press;
  logic          enable;
  logic [N-1:0]  grant;
  logic [0:0]    grant_id;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  logic [N-1:0] m_prev, m_rise, m_pend, m_grant;
  int           m_cool, m_last, m_gid, m_drop;

  always #50 clk = ~clk;

  press_arbiter #(.N_REQ(N), .COOLDOWN(CD), .DROP_W(DW)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .press    (press),
    .enable   (enable),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int           win;
    int           c;
    int           lost;
    logic [N-1:0] req;
    if (Reset) begin
      m_prev = '1; m_rise = '0; m_pend = '0; m_grant = '0;
      m_cool = 0;  m_last = N - 1; m_gid = 0; m_drop = 0;
      return;
    end
`ifdef PRESS_QUEUE_EN
    req = m_rise | m_pend;
`else
    req = m_rise;
`endif
    win = -1;
    if (m_cool == 0 && enable) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (win < 0 && req[c]) win = c;
      end
    end
    m_grant = '0;
    if (win >= 0) begin
      m_grant[win] = 1'b1;
      m_gid  = win;
      m_last = win;
      m_cool = CD;
    end else if (m_cool > 0) begin
      m_cool--;
    end
`ifdef PRESS_QUEUE_EN
    m_pend = (m_pend | m_rise) & ~m_grant;
`else
    lost = 0;
    for (int i = 0; i < N; i++) if (m_rise[i] && !m_grant[i]) lost++;
    m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
`endif
    m_rise = press & ~m_prev;
    m_prev = press;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_grant", 32'(grant), 32'(m_grant));
    chk("m_grant_id", 32'(grant_id), 32'(m_gid));
    chk("m_busy", 32'(busy), 32'(m_cool > 0));
    chk("m_drop", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int busy_cycles;
  bit q_en;

  initial begin
`ifdef PRESS_QUEUE_EN
    q_en = 1'b1;
`else
    q_en = 1'b0;
`endif
    // 1: held through reset, then re-press
    Reset = 1'b1; press = 2'b01; enable = 1'b1;
    cycles(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t1_held_grant", 32'(grant), 32'h0);
    end
    press = 2'b00; cycle();
    press = 2'b01; cycle();
    chk("t1_lat1_grant", 32'(grant), 32'h0);
    cycle();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_gid", 32'(grant_id), 32'h0);
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (busy) busy_cycles++;
    end
    chk("t1_busy_len", 32'(busy_cycles), 32'd4);
    press = 2'b00; cycles(3);

    // 2: simultaneous presses from fresh reset
    Reset = 1'b1; cycle(); Reset = 1'b0; cycle();
    press = 2'b11; cycle(); cycle();
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_drop", 32'(drop_cnt), q_en ? 32'd0 : 32'd1);
    cycles(5);
    chk("t2_second", 32'(grant), q_en ? 32'h2 : 32'h0);
    press = 2'b00; cycles(8);

    // 3: repeat, round-robin moves on
    press = 2'b11; cycle(); cycle();
    chk("t3_grant", 32'(grant), q_en ? 32'h1 : 32'h2);
    press = 2'b00; cycles(10);

    // 5: presses while disabled
    enable = 1'b0; press = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_off_grant", 32'(grant), 32'h0);
    end
    chk("t5_drop", 32'(drop_cnt), q_en ? 32'd0 : 32'd3);
    enable = 1'b1; cycle();
    chk("t5_resume", 32'(grant), q_en ? 32'h2 : 32'h0);
    press = 2'b00; cycles(8);

    // 6: reset during cooldown with ch1 pending
    press = 2'b11; cycle(); cycle();
    chk("t6_grant", 32'(grant), 32'h1);
    cycle();
    Reset = 1'b1; cycle();
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_gid", 32'(grant_id), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t6_no_grant", 32'(grant), 32'h0);
    end
    press = 2'b00; cycles(2);

    // drop counter saturation
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      press = 2'b10; cycle();
      press = 2'b00; cycle();
    end
    chk("sat_drop", 32'(drop_cnt), q_en ? 32'd0 : 32'hFF);
    enable = 1'b1;
    Reset = 1'b1; cycle(); Reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) press[0] = ~press[0];
      if ($urandom_range(0, 3) == 0) press[1] = ~press[1];
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
